alu_cmd_issuer: RTL and testbench

//  Initiator for the 6-bit combinational ALU (fxn 000..111: A, B, -A, -B, A>=B, XOR, ADD, SUB).

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_cmd_issuer_if.sv | 52 +++++
 rtl/alu_cmd_issuer.sv | 130 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer:
// function codes, widths, flag bit positions and FSM states.
package alu_pkg;

    localparam int ALU_W  = 6;
    localparam int FXN_W  = 3;
    localparam int FLAG_W = 3;

    localparam logic [FXN_W-1:0] FXN_A    = 3'b000;
    localparam logic [FXN_W-1:0] FXN_B    = 3'b001;
    localparam logic [FXN_W-1:0] FXN_NEGA = 3'b010;
    localparam logic [FXN_W-1:0] FXN_NEGB = 3'b011;
    localparam logic [FXN_W-1:0] FXN_AGEB = 3'b100;
    localparam logic [FXN_W-1:0] FXN_XOR  = 3'b101;
    localparam logic [FXN_W-1:0] FXN_ADD  = 3'b110;
    localparam logic [FXN_W-1:0] FXN_SUB  = 3'b111;

    localparam int FLG_CARRY  = 0;
    localparam int FLG_OVER   = 1;
    localparam int FLG_AGTEQB = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Request, ALU-side and response signals of the command issuer.
// master = the issuer itself, slave = command logic plus ALU.
interface alu_cmd_issuer_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = 8
);

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [FXN_W-1:0] req_fxn;

    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [FXN_W-1:0] alu_fxn;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic             alu_over;
    logic             alu_agteqb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic [FLAG_W-1:0] rsp_flags;

    logic             busy;
    logic [CNT_W-1:0] op_count;
    logic             clr_sticky;
    logic [1:0]       sticky_flags;

    modport master (
        input  req_valid, req_a, req_b, req_fxn,
        input  alu_out, alu_carry, alu_over, alu_agteqb,
        input  rsp_ready, clr_sticky,
        output req_ready, alu_x, alu_y, alu_fxn,
        output rsp_valid, rsp_data, rsp_flags,
        output busy, op_count, sticky_flags
    );

    modport slave (
        output req_valid, req_a, req_b, req_fxn,
        output alu_out, alu_carry, alu_over, alu_agteqb,
        output rsp_ready, clr_sticky,
        input  req_ready, alu_x, alu_y, alu_fxn,
        input  rsp_valid, rsp_data, rsp_flags,
        input  busy, op_count, sticky_flags
    );

endinterface

// File: rtl/alu_cmd_issuer.sv
// Drives one request at a time into the combinational ALU and returns the result.
// Define ALU_STICKY_FLAGS_EN to enable the sticky {over, carry} flags.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_W,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input logic              clk,
    input logic              rst,
    alu_cmd_issuer_if.master bus
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  alu_x_q, alu_x_d;
    logic [WIDTH-1:0]  alu_y_q, alu_y_d;
    logic [FXN_W-1:0]  alu_fxn_q, alu_fxn_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic              capture;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        alu_fxn_d   = alu_fxn_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        op_count_d  = op_count_q;
        capture     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    alu_x_d   = bus.req_a;
                    alu_y_d   = bus.req_b;
                    alu_fxn_d = bus.req_fxn;
                    cnt_d     = SETTLE_INIT;
                    state_d   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    capture                 = 1'b1;
                    rsp_data_d              = bus.alu_out;
                    rsp_flags_d[FLG_CARRY]  = bus.alu_carry;
                    rsp_flags_d[FLG_OVER]   = bus.alu_over;
                    rsp_flags_d[FLG_AGTEQB] = bus.alu_agteqb;
                    op_count_d              = op_count_q + 1'b1;
                    state_d                 = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_fxn_q   <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            alu_fxn_q   <= alu_fxn_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.alu_x     = alu_x_q;
    assign bus.alu_y     = alu_y_q;
    assign bus.alu_fxn   = alu_fxn_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.op_count  = op_count_q;

`ifdef ALU_STICKY_FLAGS_EN
    logic [1:0] sticky_q, sticky_d;

    // clear wins over a set landing in the same cycle
    always_comb begin
        sticky_d = sticky_q;
        if (capture) begin
            sticky_d = sticky_q | {bus.alu_over, bus.alu_carry};
        end
        if (bus.clr_sticky) begin
            sticky_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.sticky_flags = sticky_q;
`else
    logic unused_sticky;
    assign unused_sticky    = bus.clr_sticky | capture;
    assign bus.sticky_flags = 2'b00;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a model ALU, vector table, scoreboard,
// backpressure, reset-in-flight and counter-wrap sequences.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [2:0] f;
        logic [5:0] d;
        logic [2:0] fl;
    } vec_t;

    typedef struct {
        logic [5:0] d;
        logic [2:0] fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst4;
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    exp_t sb[$];
    vec_t vt[14];

    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.WIDTH(6), .CNT_W(8)) b1();
    alu_cmd_issuer_if #(.WIDTH(6), .CNT_W(8)) b4();

    alu_cmd_issuer #(.WIDTH(6), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst1), .bus(b1)
    );
    alu_cmd_issuer #(.WIDTH(6), .SETTLE_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst4), .bus(b4)
    );

    function automatic logic [8:0] alu_model(
        input logic [5:0] x, input logic [5:0] y, input logic [2:0] f);
        logic [6:0] s;
        logic [5:0] o;
        logic c, v, g;
        s = '0; o = '0; c = 1'b0; v = 1'b0; g = 1'b0;
        case (f)
            3'b000: o = x;
            3'b001: o = y;
            3'b010: o = ~x + 6'd1;
            3'b011: o = ~y + 6'd1;
            3'b100: g = (x >= y);
            3'b101: o = x ^ y;
            3'b110: begin
                s = {1'b0, x} + {1'b0, y};
                o = s[5:0]; c = s[6];
                v = (x[5] == y[5]) && (o[5] != x[5]);
            end
            default: begin
                s = {1'b0, x} + {1'b0, ~y} + 7'd1;
                o = s[5:0]; c = s[6];
                v = (x[5] != y[5]) && (o[5] != x[5]);
            end
        endcase
        return {g, v, c, o};
    endfunction

    always_comb begin
        {b1.alu_agteqb, b1.alu_over, b1.alu_carry, b1.alu_out} =
            alu_model(b1.alu_x, b1.alu_y, b1.alu_fxn);
        {b4.alu_agteqb, b4.alu_over, b4.alu_carry, b4.alu_out} =
            alu_model(b4.alu_x, b4.alu_y, b4.alu_fxn);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [5:0] a, input logic [5:0] b,
                          input logic [2:0] f, input logic [5:0] d,
                          input logic [2:0] fl);
        int   lat;
        exp_t e;
        @(negedge clk);
        check("req_ready_idle", b1.req_ready, 1);
        b1.req_valid = 1'b1;
        b1.req_a = a; b1.req_b = b; b1.req_fxn = f;
        sb.push_back('{d: d, fl: fl});
        @(posedge clk); #1;
        b1.req_valid = 1'b0;
        b1.req_a = ~a; b1.req_b = ~b; b1.req_fxn = ~f;
        lat = 0;
        while (!b1.rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, 1);
        e = '{d: 6'h3f, fl: 3'h7};
        if (sb.size() > 0) e = sb.pop_front();
        check("rsp_data", b1.rsp_data, e.d);
        check("rsp_flags", b1.rsp_flags, e.fl);
        check("alu_x_held", b1.alu_x, a);
        @(posedge clk); #1;
        check("rsp_done", b1.rsp_valid, 0);
        check("req_ready_after", b1.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{6'd20, 6'd15, FXN_ADD,  6'b100011, 3'b010};
        vt[1]  = '{6'd5,  6'd7,  FXN_SUB,  6'b111110, 3'b000};
        vt[2]  = '{6'd9,  6'd9,  FXN_AGEB, 6'd0,      3'b100};
        vt[3]  = '{6'd3,  6'd9,  FXN_AGEB, 6'd0,      3'b000};
        vt[4]  = '{6'd17, 6'd3,  FXN_A,    6'd17,     3'b000};
        vt[5]  = '{6'd17, 6'd42, FXN_B,    6'd42,     3'b000};
        vt[6]  = '{6'd1,  6'd0,  FXN_NEGA, 6'd63,     3'b000};
        vt[7]  = '{6'd0,  6'd5,  FXN_NEGB, 6'd59,     3'b000};
        vt[8]  = '{6'd42, 6'd15, FXN_XOR,  6'd37,     3'b000};
        vt[9]  = '{6'd63, 6'd1,  FXN_ADD,  6'd0,      3'b001};
        vt[10] = '{6'd7,  6'd5,  FXN_SUB,  6'd2,      3'b001};
        vt[11] = '{6'd31, 6'd31, FXN_ADD,  6'd62,     3'b010};
        vt[12] = '{6'd40, 6'd9,  FXN_AGEB, 6'd0,      3'b100};
        vt[13] = '{6'd32, 6'd1,  FXN_SUB,  6'd31,     3'b011};

        rst1 = 1'b1; rst4 = 1'b1;
        b1.req_valid = 0; b1.req_a = 0; b1.req_b = 0; b1.req_fxn = 0;
        b1.rsp_ready = 1; b1.clr_sticky = 0;
        b4.req_valid = 0; b4.req_a = 0; b4.req_b = 0; b4.req_fxn = 0;
        b4.rsp_ready = 1; b4.clr_sticky = 0;
        #12;
        check("rst_req_ready", b1.req_ready, 1);
        check("rst_rsp_valid", b1.rsp_valid, 0);
        check("rst_busy", b1.busy, 0);
        check("rst_op_count", b1.op_count, 0);
        check("rst_alu_x", b1.alu_x, 0);
        check("rst_alu_fxn", b1.alu_fxn, 0);
        check("rst_rsp_data", b1.rsp_data, 0);
        check("rst_rsp_flags", b1.rsp_flags, 0);
        check("rst_sticky", b1.sticky_flags, 0);
        @(negedge clk);
        rst1 = 1'b0; rst4 = 1'b0;

        // idle request pulse withheld: nothing should start
        repeat (2) @(posedge clk);
        #1 check("idle_no_start", b1.busy, 0);

        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].f, vt[i].d, vt[i].fl);
            exp_cnt++;
`ifdef ALU_STICKY_FLAGS_EN
            if (i == 0) check("sticky_after_add", b1.sticky_flags, 2'b10);
`endif
        end
        check("op_count_table", b1.op_count, exp_cnt);

        begin : backpressure
            int   lat;
            exp_t e;
            b1.rsp_ready = 1'b0;
            @(negedge clk);
            b1.req_valid = 1; b1.req_a = 6'd31; b1.req_b = 6'd31;
            b1.req_fxn = FXN_ADD;
            sb.push_back('{d: 6'd62, fl: 3'b010});
            @(posedge clk); #1;
            b1.req_valid = 0;
            lat = 0;
            while (!b1.rsp_valid && lat < 20) begin
                @(posedge clk); #1; lat++;
            end
            check("bp_latency", lat, 1);
            e = '{d: 6'h3f, fl: 3'h7};
            if (sb.size() > 0) e = sb.pop_front();
            b1.req_valid = 1; b1.req_a = 6'd1; b1.req_b = 6'd2;
            b1.req_fxn = FXN_SUB;
            repeat (5) begin
                @(posedge clk); #1;
                check("bp_rsp_valid", b1.rsp_valid, 1);
                check("bp_rsp_data", b1.rsp_data, e.d);
                check("bp_rsp_flags", b1.rsp_flags, e.fl);
                check("bp_req_ready", b1.req_ready, 0);
            end
            b1.req_valid = 0;
            b1.rsp_ready = 1;
            @(posedge clk); #1;
            exp_cnt++;
            check("bp_release", b1.rsp_valid, 0);
            check("bp_idle_ready", b1.req_ready, 1);
            check("bp_no_second", b1.alu_x, 31);
            check("bp_op_count", b1.op_count, exp_cnt);
        end

`ifdef ALU_STICKY_FLAGS_EN
        check("sticky_accum", b1.sticky_flags, 2'b11);
`endif
        @(negedge clk); b1.clr_sticky = 1;
        @(negedge clk); b1.clr_sticky = 0;
        check("sticky_cleared", b1.sticky_flags, 2'b00);

        begin : reset_in_drive
            int lat;
            @(negedge clk);
            b4.req_valid = 1; b4.req_a = 6'd20; b4.req_b = 6'd15;
            b4.req_fxn = FXN_ADD;
            @(posedge clk); #1;
            b4.req_valid = 0;
            @(posedge clk); #1;
            check("s4_busy_drive", b4.busy, 1);
            check("s4_no_rsp_yet", b4.rsp_valid, 0);
            rst4 = 1'b1;
            #1;
            check("s4_rst_rsp_valid", b4.rsp_valid, 0);
            check("s4_rst_req_ready", b4.req_ready, 1);
            check("s4_rst_op_count", b4.op_count, 0);
            check("s4_rst_alu_x", b4.alu_x, 0);
            @(negedge clk); rst4 = 1'b0;
            @(negedge clk);
            b4.req_valid = 1; b4.req_a = 6'd20; b4.req_b = 6'd15;
            b4.req_fxn = FXN_ADD;
            @(posedge clk); #1;
            b4.req_valid = 0;
            lat = 0;
            while (!b4.rsp_valid && lat < 40) begin
                @(posedge clk); #1; lat++;
                if (!b4.rsp_valid) check("s4_alu_stable", b4.alu_x, 20);
            end
            check("s4_latency", lat, 4);
            check("s4_rsp_data", b4.rsp_data, 6'b100011);
            check("s4_rsp_flags", b4.rsp_flags, 3'b010);
            check("s4_op_count", b4.op_count, 1);
        end

        @(negedge clk); rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            logic [5:0] a, b;
            logic [2:0] f;
            logic [8:0] m;
            a = 6'($urandom_range(0, 63));
            b = 6'($urandom_range(0, 63));
            f = 3'($urandom_range(0, 7));
            m = alu_model(a, b, f);
            run_op(a, b, f, m[5:0], m[8:6]);
            if (i == 254) check("op_count_255", b1.op_count, 255);
        end
        check("op_count_wrap", b1.op_count, 0);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
